// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared definitions for the memory access controller.
//               Provides the BHW size encodings, the memory control value
//               used while idle or in reset, the controller state encoding
//               and the access alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  // BHW field of the {BHW[1:0],U} control word
  localparam logic [1:0] BHW_BYTE = 2'b00;
  localparam logic [1:0] BHW_HALF = 2'b01;
  localparam logic [1:0] BHW_WORD = 2'b10;

  // Control value presented to the memory out of reset (word, U=0)
  localparam logic [2:0] CTRL_RST = 3'b100;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Returns 1 when the access size is legal and naturally aligned.
  function automatic logic access_ok(input logic [1:0] addr_lo,
                                     input logic [1:0] bhw);
    logic ok;
    case (bhw)
      BHW_BYTE: ok = 1'b1;
      BHW_HALF: ok = ~addr_lo[0];
      BHW_WORD: ok = (addr_lo == 2'b00);
      default:  ok = 1'b0;  // BHW=11 has no meaning to the memory
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arbiter
// Description : Two-way round-robin arbiter. A lone requester always wins;
//               under contention the requester not granted last time wins.
// Ports       : valid_i      - request valids {req1, req0}
//               last_grant_i - index of the previously granted requester
//               grant_o      - one-hot grant {req1, req0}, zero if none valid
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Shares one tri-state data memory between a core port (0)
//               and a debug/DMA port (1). Round-robin arbitration with
//               valid/ready handshakes, a fixed SETUP/ACCESS/RESP sequence
//               per access, alignment checking and a memory clear after
//               reset.
// Ports       : clk, rst_n            - clock, async active-low reset
//               reqK_valid/ready      - request handshake
//               reqK_we/addr/ctrl/wdata - request command
//               rspK_valid/rdata/err  - one-cycle response to the owner
//               mem_address/data/control_signals/write_enable/rst
//                                     - memory interface
//               busy                  - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 7,
  parameter int INIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [2:0]            req0_ctrl,
  input  logic [31:0]           req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [2:0]            req1_ctrl,
  input  logic [31:0]           req1_wdata,
  output logic                  rsp0_valid,
  output logic [31:0]           rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic [31:0]           rsp1_rdata,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [31:0]           mem_data,
  output logic [2:0]            mem_control_signals,
  output logic                  mem_write_enable,
  output logic                  mem_rst,
  output logic                  busy
);

  localparam int                c_cnt_w    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(INIT_CYCLES - 1);

  state_t                  state_q;
  logic [c_cnt_w-1:0]      cnt_q;
  logic                    mem_rst_q;
  logic                    last_grant_q;
  logic                    owner_q;
  logic                    store_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              ctrl_q;
  logic [31:0]             wdata_q;
  logic                    we_q;
  logic                    rsp0_valid_q, rsp1_valid_q;
  logic                    rsp0_err_q, rsp1_err_q;
  logic [31:0]             rsp0_rdata_q, rsp1_rdata_q;

  logic [1:0]              w_grant;
  logic                    w_hs;
  logic                    w_owner;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [2:0]              w_ctrl;
  logic [31:0]             w_wdata;
  logic                    w_ok;

  mem_rr_arbiter u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (w_grant)
  );

  // Ready is only offered in IDLE; the grant already implies valid.
  assign req0_ready = (state_q == ST_IDLE) && w_grant[0];
  assign req1_ready = (state_q == ST_IDLE) && w_grant[1];

  assign w_hs    = req0_ready | req1_ready;
  assign w_owner = req1_ready;
  assign w_we    = w_owner ? req1_we    : req0_we;
  assign w_addr  = w_owner ? req1_addr  : req0_addr;
  assign w_ctrl  = w_owner ? req1_ctrl  : req0_ctrl;
  assign w_wdata = w_owner ? req1_wdata : req0_wdata;
  assign w_ok    = access_ok(w_addr[1:0], w_ctrl[2:1]);

  // One flop drives both the write strobe and the bus output enable so the
  // controller can never drive the bus while the memory is driving it.
  assign mem_data            = we_q ? wdata_q : 'z;
  assign mem_write_enable    = we_q;
  assign mem_address         = addr_q;
  assign mem_control_signals = ctrl_q;
  assign mem_rst             = mem_rst_q;
  assign busy                = (state_q != ST_IDLE);
  assign rsp0_valid          = rsp0_valid_q;
  assign rsp1_valid          = rsp1_valid_q;
  assign rsp0_err            = rsp0_err_q;
  assign rsp1_err            = rsp1_err_q;
  assign rsp0_rdata          = rsp0_rdata_q;
  assign rsp1_rdata          = rsp1_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      mem_rst_q    <= 1'b1;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      store_q      <= 1'b0;
      addr_q       <= '0;
      ctrl_q       <= CTRL_RST;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == c_cnt_last) begin
            mem_rst_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_IDLE: begin
          if (w_hs) begin
            owner_q      <= w_owner;
            last_grant_q <= w_owner;
            if (w_ok) begin
              // Address/control only move here, while the write strobe is low.
              addr_q  <= w_addr;
              ctrl_q  <= w_ctrl;
              store_q <= w_we;
              wdata_q <= w_wdata;
              state_q <= ST_SETUP;
            end else begin
              // Rejected access: answer next cycle without touching memory.
              rsp0_valid_q <= ~w_owner;
              rsp1_valid_q <= w_owner;
              rsp0_err_q   <= ~w_owner;
              rsp1_err_q   <= w_owner;
              rsp0_rdata_q <= '0;
              rsp1_rdata_q <= '0;
              state_q      <= ST_RESP;
            end
          end
        end

        ST_SETUP: begin
          we_q    <= store_q;
          state_q <= ST_ACCESS;
        end

        ST_ACCESS: begin
          we_q         <= 1'b0;
          rsp0_valid_q <= ~owner_q;
          rsp1_valid_q <= owner_q;
          rsp0_err_q   <= 1'b0;
          rsp1_err_q   <= 1'b0;
          rsp0_rdata_q <= (~owner_q && ~store_q) ? mem_data : '0;
          rsp1_rdata_q <= ( owner_q && ~store_q) ? mem_data : '0;
          state_q      <= ST_RESP;
        end

        ST_RESP: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          rsp0_err_q   <= 1'b0;
          rsp1_err_q   <= 1'b0;
          rsp0_rdata_q <= '0;
          rsp1_rdata_q <= '0;
          state_q      <= ST_IDLE;
        end

        default: begin
          we_q      <= 1'b0;
          mem_rst_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_INIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. Contains a byte
//               memory on the tri-state bus, a transaction-level reference
//               model checked every cycle, and directed scenarios with
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int AW   = 7;
  localparam int INIT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_we = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [2:0]    req0_ctrl = '0, req1_ctrl = '0;
  logic [31:0]   req0_wdata = '0, req1_wdata = '0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0]   rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] mem_address;
  wire  [31:0]   mem_data;
  logic [2:0]    mem_control_signals;
  logic          mem_write_enable, mem_rst, busy;

  mem_access_ctrl #(.ADDR_WIDTH(AW), .INIT_CYCLES(INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_ctrl(req0_ctrl), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_ctrl(req1_ctrl), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_control_signals(mem_control_signals),
    .mem_write_enable(mem_write_enable), .mem_rst(mem_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory on the bus ----------------
  logic [7:0]  bmem [0:127];
  logic [31:0] bus_rd;

  always_comb begin
    bus_rd = '0;
    case (mem_control_signals[2:1])
      2'b00:   bus_rd = {24'h0, bmem[mem_address]};
      2'b01:   bus_rd = {16'h0, bmem[mem_address + 7'd1], bmem[mem_address]};
      default: bus_rd = {bmem[mem_address + 7'd3], bmem[mem_address + 7'd2],
                         bmem[mem_address + 7'd1], bmem[mem_address]};
    endcase
  end

  assign mem_data = mem_write_enable ? 'z : bus_rd;

  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < 128; i++) bmem[i] <= 8'h00;
    end else if (mem_write_enable) begin
      bmem[mem_address] <= mem_data[7:0];
      if (mem_control_signals[2:1] != 2'b00) bmem[mem_address + 7'd1] <= mem_data[15:8];
      if (mem_control_signals[2:1] == 2'b10) begin
        bmem[mem_address + 7'd2] <= mem_data[23:16];
        bmem[mem_address + 7'd3] <= mem_data[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] gmem [0:127];

  function automatic bit legal(input logic [6:0] a, input logic [2:0] c);
    case (c[2:1])
      2'b00:   return 1'b1;
      2'b01:   return a[0] == 1'b0;
      2'b10:   return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] gread(input logic [6:0] a, input logic [2:0] c);
    case (c[2:1])
      2'b00:   return {24'h0, gmem[a]};
      2'b01:   return {16'h0, gmem[a + 7'd1], gmem[a]};
      default: return {gmem[a + 7'd3], gmem[a + 7'd2], gmem[a + 7'd1], gmem[a]};
    endcase
  endfunction

  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int          m_free_at = 0;
  bit          m_last = 1'b1;
  bit          acc_v = 1'b0, acc_st = 1'b0;
  int          acc_t = 0;
  logic [6:0]  acc_addr = '0;
  logic [2:0]  acc_ctrl = '0;
  logic [31:0] acc_wd = '0;
  bit          rsp_v = 1'b0, rsp_o = 1'b0, rsp_e = 1'b0;
  int          rsp_t = 0;
  logic [31:0] rsp_d = '0;

  int          we_cycles = 0;
  int          rsp_pulses = 0;
  int          hs_cyc [2];
  int          last_rsp_cyc [2];
  logic [31:0] last_rsp_data [2];
  logic        last_rsp_err [2];
  bit          grant_log [$];

  always @(negedge clk) begin
    bit          idle, g, ev0, ev1, exp_we;
    logic [6:0]  a;
    logic [2:0]  c;
    logic [31:0] d;
    bit          w;
    if (!rst_n) begin
      chk1("rst_ready0", req0_ready, 1'b0);
      chk1("rst_ready1", req1_ready, 1'b0);
      chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
      chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
      chk32("rst_rsp0_rdata", rsp0_rdata, 32'h0);
      chk32("rst_rsp1_rdata", rsp1_rdata, 32'h0);
      chk1("rst_err", rsp0_err | rsp1_err, 1'b0);
      chk1("rst_we", mem_write_enable, 1'b0);
      chk1("rst_mem_rst", mem_rst, 1'b1);
      chk1("rst_busy", busy, 1'b1);
      chk32("rst_addr", 32'(mem_address), 32'h0);
      chk32("rst_ctrl", 32'(mem_control_signals), 32'h4);
      m_free_at = 0; m_last = 1'b1; acc_v = 1'b0; rsp_v = 1'b0;
      for (int i = 0; i < 128; i++) gmem[i] = 8'h00;
    end else begin
      idle = (cyc >= INIT) && (cyc >= m_free_at);
      chk1("mem_rst", mem_rst, cyc < INIT);
      chk1("busy", busy, !idle);

      exp_we = acc_v && acc_st && (cyc == acc_t + 2);
      chk1("write_enable", mem_write_enable, exp_we);
      if (mem_write_enable) we_cycles++;
      if (exp_we) chk32("bus_store_data", mem_data, acc_wd);
      else        chk32("bus_released", mem_data, bus_rd);
      if (acc_v && cyc >= acc_t + 1 && cyc <= acc_t + 3) begin
        chk32("mem_address", 32'(mem_address), 32'(acc_addr));
        chk32("mem_ctrl", 32'(mem_control_signals), 32'(acc_ctrl));
      end

      ev0 = rsp_v && (cyc == rsp_t) && !rsp_o;
      ev1 = rsp_v && (cyc == rsp_t) && rsp_o;
      chk1("rsp0_valid", rsp0_valid, ev0);
      chk1("rsp1_valid", rsp1_valid, ev1);
      if (rsp0_valid || rsp1_valid) rsp_pulses++;
      if (ev0) begin
        chk32("rsp0_rdata", rsp0_rdata, rsp_d);
        chk1("rsp0_err", rsp0_err, rsp_e);
        last_rsp_cyc[0] = cyc; last_rsp_data[0] = rsp0_rdata; last_rsp_err[0] = rsp0_err;
      end
      if (ev1) begin
        chk32("rsp1_rdata", rsp1_rdata, rsp_d);
        chk1("rsp1_err", rsp1_err, rsp_e);
        last_rsp_cyc[1] = cyc; last_rsp_data[1] = rsp1_rdata; last_rsp_err[1] = rsp1_err;
      end
      if (rsp_v && cyc == rsp_t) rsp_v = 1'b0;

      // Arbitration and acceptance of a new command
      g = (req0_valid && req1_valid) ? !m_last : req1_valid;
      chk1("req0_ready", req0_ready, idle && req0_valid && !g);
      chk1("req1_ready", req1_ready, idle && req1_valid && g);
      if (idle && (req0_valid || req1_valid)) begin
        a = g ? req1_addr  : req0_addr;
        c = g ? req1_ctrl  : req0_ctrl;
        d = g ? req1_wdata : req0_wdata;
        w = g ? req1_we    : req0_we;
        grant_log.push_back(g);
        hs_cyc[g] = cyc;
        last_rsp_cyc[g] = -1;
        m_last = g;
        rsp_v = 1'b1;
        rsp_o = g;
        if (legal(a, c)) begin
          acc_v = 1'b1; acc_t = cyc; acc_addr = a; acc_ctrl = c; acc_st = w; acc_wd = d;
          rsp_t = cyc + 3; rsp_e = 1'b0;
          rsp_d = w ? 32'h0 : gread(a, c);
          m_free_at = cyc + 4;
          if (w) begin
            gmem[a] = d[7:0];
            if (c[2:1] != 2'b00) gmem[a + 7'd1] = d[15:8];
            if (c[2:1] == 2'b10) begin
              gmem[a + 7'd2] = d[23:16];
              gmem[a + 7'd3] = d[31:24];
            end
          end
        end else begin
          rsp_t = cyc + 1; rsp_e = 1'b1; rsp_d = 32'h0;
          m_free_at = cyc + 2;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
  task automatic issue(input bit p, input bit we, input logic [6:0] a,
                       input logic [2:0] c, input logic [31:0] d);
    bit done;
    done = 1'b0;
    if (!p) begin
      req0_we = we; req0_addr = a; req0_ctrl = c; req0_wdata = d; req0_valid = 1'b1;
    end else begin
      req1_we = we; req1_addr = a; req1_ctrl = c; req1_wdata = d; req1_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (p ? req1_ready : req0_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!p) req0_valid = 1'b0;
    else    req1_valid = 1'b0;
    chk1("handshake_seen", done, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, we0, p0;
    step(3);
    rst_n = 1'b1;

    // 1: mem_rst held exactly two cycles, then idle
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_rst) n++;
    end
    chk32("init_mem_rst_cycles", 32'(n), 32'd2);
    chk1("idle_not_busy", busy, 1'b0);
    step(1);

    // 2: store word then load it back
    we0 = we_cycles;
    issue(1'b0, 1'b1, 7'h08, 3'b100, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 7'h08, 3'b100, 32'h0);
    step(5);
    chk32("sw_we_cycles", 32'(we_cycles - we0), 32'd1);
    chk32("lw_rdata", last_rsp_data[0], 32'hDEADBEEF);
    chk1("lw_err", last_rsp_err[0], 1'b0);
    chk32("lw_latency", 32'(last_rsp_cyc[0] - hs_cyc[0]), 32'd3);

    // 5: store byte then load byte
    issue(1'b0, 1'b1, 7'h0D, 3'b000, 32'h000000AB);
    issue(1'b0, 1'b0, 7'h0D, 3'b000, 32'h0);
    step(5);
    chk32("lb_rdata", last_rsp_data[0], 32'h000000AB);

    // 4: misaligned half and illegal size on requester 1
    we0 = we_cycles;
    issue(1'b1, 1'b0, 7'h05, 3'b010, 32'h0);
    step(3);
    chk1("lh_mis_err", last_rsp_err[1], 1'b1);
    chk32("lh_mis_rdata", last_rsp_data[1], 32'h0);
    chk32("lh_mis_latency", 32'(last_rsp_cyc[1] - hs_cyc[1]), 32'd1);
    issue(1'b1, 1'b0, 7'h04, 3'b110, 32'h0);
    step(3);
    chk1("bhw11_err", last_rsp_err[1], 1'b1);
    chk32("bhw11_latency", 32'(last_rsp_cyc[1] - hs_cyc[1]), 32'd1);
    chk32("err_no_write", 32'(we_cycles - we0), 32'd0);

    // 6: reset asserted during the ACCESS cycle of a store
    issue(1'b0, 1'b1, 7'h20, 3'b100, 32'h12345678);
    @(posedge clk);
    #1;
    chk1("access_we_high", mem_write_enable, 1'b1);
    p0 = rsp_pulses;
    rst_n = 1'b0;
    #1;
    chk1("async_we_drop", mem_write_enable, 1'b0);
    chk1("async_mem_rst", mem_rst, 1'b1);
    step(3);
    chk32("no_rsp_after_abort", 32'(rsp_pulses - p0), 32'd0);
    grant_log.delete();
    rst_n = 1'b1;

    // 3: both requesters valid from INIT onward, alternating grants
    fork
      begin
        issue(1'b0, 1'b1, 7'h10, 3'b100, 32'h11112222);
        issue(1'b0, 1'b0, 7'h10, 3'b100, 32'h0);
      end
      begin
        issue(1'b1, 1'b1, 7'h14, 3'b100, 32'h33334444);
        issue(1'b1, 1'b0, 7'h14, 3'b100, 32'h0);
      end
    join
    step(5);
    chk32("grant_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk1("grant_0", grant_log[0], 1'b0);
      chk1("grant_1", grant_log[1], 1'b1);
      chk1("grant_2", grant_log[2], 1'b0);
      chk1("grant_3", grant_log[3], 1'b1);
    end
    chk32("rr_rdata0", last_rsp_data[0], 32'h11112222);
    chk32("rr_rdata1", last_rsp_data[1], 32'h33334444);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
